// File: rtl/tinyml_cmd_slice.sv
// Register slice between the CPU custom-instruction port and a tinyML accelerator.
// Commands pass through a 2-entry skid buffer and are credit-limited; responses queue in a FIFO.
module tinyml_cmd_slice #(
    parameter int RSP_DEPTH = 4,
    parameter int CNT_W     = $clog2(RSP_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_cmd_valid,
    input  logic [9:0]       s_cmd_function_id,
    input  logic [31:0]      s_cmd_inputs_0,
    input  logic [31:0]      s_cmd_inputs_1,
    output logic             s_cmd_ready,
    output logic             s_rsp_valid,
    output logic [31:0]      s_rsp_outputs_0,
    input  logic             s_rsp_ready,
    output logic             s_cmd_int,
    output logic             m_cmd_valid,
    output logic [9:0]       m_cmd_function_id,
    output logic [31:0]      m_cmd_inputs_0,
    output logic [31:0]      m_cmd_inputs_1,
    input  logic             m_cmd_ready,
    input  logic             m_cmd_int,
    input  logic             m_rsp_valid,
    input  logic [31:0]      m_rsp_outputs_0,
    output logic             m_rsp_ready,
    output logic [CNT_W-1:0] outstanding
);
    localparam int AW = $clog2(RSP_DEPTH);
    localparam int PW = 74;

    logic [PW-1:0]    main_data_q, main_data_d;
    logic [PW-1:0]    skid_data_q, skid_data_d;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_ready_q, rsp_ready_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             int_q;
    logic [31:0]      mem [RSP_DEPTH];

    logic [PW-1:0] s_payload;
    logic          s_acc;
    logic          m_fire;
    logic          push;
    logic          pop;

    assign s_payload = {s_cmd_function_id, s_cmd_inputs_1, s_cmd_inputs_0};
    assign s_acc     = s_cmd_valid & ~skid_valid_q;
    assign m_fire    = cmd_valid_q & m_cmd_ready;
    assign push      = m_rsp_valid & rsp_ready_q;
    assign pop       = rsp_valid_q & s_rsp_ready;

    // Skid buffer: the skid entry only fills while the main entry is stalled.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!main_valid_q || m_fire) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (s_acc) begin
                main_valid_d = 1'b1;
                main_data_d  = s_payload;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (s_acc) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_payload;
        end
    end

    // Credit counter; a response with nothing outstanding saturates at zero.
    always_comb begin
        outstanding_d = outstanding_q;
        if (m_fire && !pop) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (pop && !m_fire && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
        cmd_valid_d = main_valid_d && (outstanding_d < CNT_W'(RSP_DEPTH));
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
        rsp_valid_d = (wr_ptr_d != rd_ptr_d);
        rsp_data_d  = rsp_data_q;
        // When the new head is the entry being written this cycle, bypass the array.
        if (rsp_valid_d) begin
            if (rd_ptr_d == wr_ptr_q) begin
                rsp_data_d = m_rsp_outputs_0;
            end else begin
                rsp_data_d = mem[rd_ptr_d[AW-1:0]];
            end
        end
        rsp_ready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                        (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= m_rsp_outputs_0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_data_q   <= '0;
            skid_data_q   <= '0;
            main_valid_q  <= 1'b0;
            skid_valid_q  <= 1'b0;
            cmd_valid_q   <= 1'b0;
            outstanding_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_ready_q   <= 1'b1;
            rsp_data_q    <= '0;
            int_q         <= 1'b0;
        end else begin
            main_data_q   <= main_data_d;
            skid_data_q   <= skid_data_d;
            main_valid_q  <= main_valid_d;
            skid_valid_q  <= skid_valid_d;
            cmd_valid_q   <= cmd_valid_d;
            outstanding_q <= outstanding_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_ready_q   <= rsp_ready_d;
            rsp_data_q    <= rsp_data_d;
            int_q         <= m_cmd_int;
        end
    end

    assign s_cmd_ready       = ~skid_valid_q;
    assign m_cmd_valid       = cmd_valid_q;
    assign m_cmd_function_id = main_data_q[73:64];
    assign m_cmd_inputs_1    = main_data_q[63:32];
    assign m_cmd_inputs_0    = main_data_q[31:0];
    assign m_rsp_ready       = rsp_ready_q;
    assign s_rsp_valid       = rsp_valid_q;
    assign s_rsp_outputs_0   = rsp_data_q;
    assign s_cmd_int         = int_q;
    assign outstanding       = outstanding_q;

endmodule

// File: doc/tinyml_cmd_slice.md
# tinyml_cmd_slice

Registered pipeline stage between the CPU custom-instruction port and the tinyML command/response interface. It breaks the combinational cmd/rsp paths with a 2-entry command skid buffer and a response FIFO, and credit-limits issued commands so responses are never dropped. It also registers the accelerator interrupt.

## Interface
- RSP_DEPTH, 4: response FIFO depth and maximum outstanding commands; power of two, 2..16.
- CNT_W, $clog2(RSP_DEPTH)+1: width of the outstanding counter.
- clk  in  1  single clock for all logic.
- rstn  in  1  asynchronous active-low reset.
- s_cmd_valid  in  1  CPU command valid.
- s_cmd_function_id  in  10  CPU function ID.
- s_cmd_inputs_0  in  32  operand 0.
- s_cmd_inputs_1  in  32  operand 1.
- s_cmd_ready  out  1  slice can accept a command; registered.
- s_rsp_valid  out  1  response to CPU valid; registered.
- s_rsp_outputs_0  out  32  response data; registered.
- s_rsp_ready  in  1  CPU accepts response.
- s_cmd_int  out  1  m_cmd_int delayed by one clk.
- m_cmd_valid  out  1  command to accelerator valid; registered.
- m_cmd_function_id  out  10  forwarded function ID.
- m_cmd_inputs_0  out  32  forwarded operand 0.
- m_cmd_inputs_1  out  32  forwarded operand 1.
- m_cmd_ready  in  1  accelerator accepts command.
- m_cmd_int  in  1  accelerator interrupt.
- m_rsp_valid  in  1  accelerator response valid.
- m_rsp_outputs_0  in  32  accelerator response data.
- m_rsp_ready  out  1  slice can accept a response; registered.
- outstanding  out  CNT_W  commands issued downstream and not yet returned to the CPU.

## Operation
- Command skid buffer: 2 entries (main + skid), 74-bit payload {function_id, inputs_1, inputs_0}, in-order.
  - s_cmd_ready = skid entry empty.
  - The main entry drives m_cmd_*.
  - m_cmd_valid = main entry valid AND credit available.
  - Payload is held stable while m_cmd_valid=1 and m_cmd_ready=0.
- Credit: credit available when outstanding < RSP_DEPTH.
  - outstanding +1 on m_cmd handshake (m_cmd_valid & m_cmd_ready).
  - outstanding −1 on s_rsp handshake (s_rsp_valid & s_rsp_ready).
  - Both handshakes in the same cycle: outstanding unchanged.
  - Once m_cmd_valid is asserted it stays high until the handshake; it deasserts only after the handshake completes or on reset.
- Response FIFO: RSP_DEPTH entries × 32 bits; registered output head drives s_rsp_*.
  - m_rsp_ready = FIFO not full.
  - A push with m_rsp_valid & !m_rsp_ready is the upstream's responsibility; the credit scheme makes it unreachable.
  - Push and pop in the same cycle while full: pop frees the entry; the push is still refused because m_rsp_ready is registered.
  - Pointers are (log2 RSP_DEPTH)+1 bits with wrap bit. Full = pointers equal except MSB; empty = pointers equal.
- Response without command: if m_rsp_valid arrives while outstanding==0, it is still accepted and delivered. Decrement at outstanding==0 saturates at 0, no wrap.
- Function IDs are forwarded unmodified; no decoding of bit 9 is done here.

## Timing
- Reset values:
  - s_cmd_ready=1, m_cmd_valid=0, m_rsp_ready=1, s_rsp_valid=0.
  - s_rsp_outputs_0=0, m_cmd_* payload=0, s_cmd_int=0, outstanding=0.
  - FIFO pointers=0, buffer entries invalid.
- Reset mid-operation: all state clears asynchronously; in-flight commands and queued responses are discarded.
- Command latency: s_cmd handshake at cycle N → m_cmd_valid=1 at N+1, when the buffer is empty and credit is available.
- Command throughput: one command per cycle while m_cmd_ready=1.
- Skid entry fills only when the main entry is stalled. s_cmd_ready drops in the cycle after the skid entry fills.
- Response latency: m_rsp handshake at N → s_rsp_valid=1 at N+1 when the FIFO was empty. Back-to-back responses sustain 1/cycle.
- Credit effect: the credit freed by an s_rsp handshake at N allows m_cmd_valid at N+1.
- s_cmd_int = m_cmd_int registered; exactly 1 cycle delay.

## Test plan
- Single command: s_cmd {id=0x005, in0=0x11223344, in1=0xAABBCCDD} at cycle 0, m_cmd_ready=1 → m_cmd_* matches at cycle 1, outstanding=1. Then m_rsp 0xDEADBEEF → s_rsp_outputs_0=0xDEADBEEF one cycle later; outstanding returns to 0 after s_rsp handshake.
- Backpressure: hold m_cmd_ready=0 and send 3 commands → first two are accepted and s_cmd_ready=0. Release → commands emerge in order with unchanged payloads, no loss or duplication.
- Credit limit, RSP_DEPTH=4, s_rsp_ready=0: issue 6 commands → exactly 4 m_cmd handshakes, outstanding=4, m_cmd_valid=0. One s_rsp handshake → 5th command issues the next cycle.
- FIFO full/wrap: 4 responses queued with s_rsp_ready=0 → m_rsp_ready=0. Then drain while pushing 8 more → all 12 values delivered in order with pointer wrap exercised.
- Simultaneous push/pop and inc/dec in the same cycle → outstanding unchanged, FIFO count unchanged.
- Async reset asserted with 2 queued responses and a stalled command → all outputs at reset values immediately. After release, the next command is forwarded normally; m_cmd_int pulse → s_cmd_int pulse 1 cycle later.
